// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM states and Funct3 access encodings.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load lane select and sign/zero extension of a read word, purely combinational.
module mem_access_stage_load_extend
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'd0;
        unique case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: drives the req/ack data bus, stalls while busy, captures load
// data across external holds, flags misalignment and raises a one-cycle bus-timeout pulse.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Valid_M,
    input  logic        MEM_R_En_M,
    input  logic        MEM_W_En_M,
    input  logic [2:0]  Funct3_M,
    input  logic [31:0] ALU_Out_M,
    input  logic [31:0] Store_Data_M,
    input  logic        Hold_M,
    output logic        DMEM_Req,
    output logic        DMEM_We,
    output logic [31:0] DMEM_Addr,
    output logic [31:0] DMEM_WData,
    output logic [3:0]  DMEM_BE,
    input  logic        DMEM_Ack,
    input  logic [31:0] DMEM_RData,
    output logic [31:0] Data_Out_Ext_M,
    output logic        Stall_M,
    output logic        Misaligned_M,
    output logic        Bus_Err_M
);

    mem_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]      r_data, w_data_nxt;

    logic        w_rw, w_is_h, w_is_w, w_mis, w_access, w_load, w_timeout;
    logic [31:0] w_ext, w_wdata, w_dout;
    logic [3:0]  w_be;
    logic        w_req, w_stall, w_bus_err;

    assign w_rw      = MEM_R_En_M | MEM_W_En_M;
    assign w_is_h    = (Funct3_M == F3_H) || (Funct3_M == F3_HU);
    assign w_is_w    = (Funct3_M == F3_W);
    assign w_mis     = Valid_M & w_rw &
                       ((w_is_h & ALU_Out_M[0]) | (w_is_w & (ALU_Out_M[1:0] != 2'b00)));
    assign w_access  = Valid_M & w_rw & ~w_mis;
    assign w_load    = Valid_M & MEM_R_En_M;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    mem_access_stage_load_extend u_load_extend (
        .i_addr_lo (ALU_Out_M[1:0]),
        .i_funct3  (Funct3_M),
        .i_rdata   (DMEM_RData),
        .o_data    (w_ext)
    );

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = Store_Data_M;
        case (Funct3_M)
            F3_B, F3_BU: begin
                w_be    = 4'b0001 << ALU_Out_M[1:0];
                w_wdata = {4{Store_Data_M[7:0]}};
            end
            F3_H, F3_HU: begin
                w_be    = ALU_Out_M[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{Store_Data_M[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_bus_err   = 1'b0;
        w_dout      = 32'd0;
        unique case (r_state)
            IDLE: begin
                w_req = w_access;
                if (w_access) begin
                    if (DMEM_Ack) begin
                        if (w_load) w_dout = w_ext;
                        if (Hold_M) begin
                            w_state_nxt = DONE;
                            w_data_nxt  = w_load ? w_ext : 32'd0;
                        end
                    end else begin
                        w_stall     = 1'b1;
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (DMEM_Ack) begin
                    w_req       = 1'b1;
                    if (w_load) w_dout = w_ext;
                    w_data_nxt  = w_load ? w_ext : 32'd0;
                    w_state_nxt = Hold_M ? DONE : IDLE;
                end else if (w_timeout) begin
                    // Request drops here, so a late ack finds no outstanding access.
                    w_bus_err   = 1'b1;
                    w_data_nxt  = 32'd0;
                    w_state_nxt = Hold_M ? DONE : IDLE;
                end else begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                end
            end
            DONE: begin
                w_dout = r_data;
                if (!Hold_M) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign DMEM_Req       = RST_N & w_req;
    assign DMEM_We        = RST_N & w_req & MEM_W_En_M;
    assign DMEM_Addr      = RST_N ? {ALU_Out_M[31:2], 2'b00} : 32'd0;
    assign DMEM_WData     = RST_N ? w_wdata : 32'd0;
    assign DMEM_BE        = RST_N ? w_be : 4'd0;
    assign Data_Out_Ext_M = RST_N ? w_dout : 32'd0;
    assign Stall_M        = RST_N & w_stall;
    assign Misaligned_M   = RST_N & w_mis;
    assign Bus_Err_M      = RST_N & w_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage with a byte-arithmetic reference model.
module tb_mem_access_stage;

    localparam int unsigned TO = 16;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    logic        CLK, RST_N, Valid_M, MEM_R_En_M, MEM_W_En_M, Hold_M, DMEM_Ack;
    logic [2:0]  Funct3_M;
    logic [31:0] ALU_Out_M, Store_Data_M, DMEM_RData;
    logic        DMEM_Req, DMEM_We, Stall_M, Misaligned_M, Bus_Err_M;
    logic [31:0] DMEM_Addr, DMEM_WData, Data_Out_Ext_M;
    logic [3:0]  DMEM_BE;

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .Valid_M(Valid_M), .MEM_R_En_M(MEM_R_En_M),
        .MEM_W_En_M(MEM_W_En_M), .Funct3_M(Funct3_M), .ALU_Out_M(ALU_Out_M),
        .Store_Data_M(Store_Data_M), .Hold_M(Hold_M), .DMEM_Req(DMEM_Req), .DMEM_We(DMEM_We),
        .DMEM_Addr(DMEM_Addr), .DMEM_WData(DMEM_WData), .DMEM_BE(DMEM_BE),
        .DMEM_Ack(DMEM_Ack), .DMEM_RData(DMEM_RData), .Data_Out_Ext_M(Data_Out_Ext_M),
        .Stall_M(Stall_M), .Misaligned_M(Misaligned_M), .Bus_Err_M(Bus_Err_M)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // kind: 0 completed access, 1 misaligned, 2 bus timeout
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] dout;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input bit rd, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] sd, input logic [31:0] rdata,
                                   input bit timeout);
        exp_t   e;
        int     off, size;
        longint v;
        off  = int'(addr % 4);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e.addr = addr - off;
        e.we   = !rd;
        e.be   = 4'(((1 << size) - 1) << off);
        case (size)
            1:       e.wdata = sd[7:0] * 32'h0101_0101;
            2:       e.wdata = sd[15:0] * 32'h0001_0001;
            default: e.wdata = sd;
        endcase
        e.dout = 32'd0;
        if (off % size != 0) e.kind = 1;
        else if (timeout) e.kind = 2;
        else begin
            e.kind = 0;
            if (rd) begin
                v = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
                if (!f3[2] && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
                e.dout = v[31:0];
            end
        end
        return e;
    endfunction

    // Monitor: every completion, timeout or misalignment consumes one expected record.
    always @(negedge CLK) begin
        exp_t e;
        int   kind_act;
        if (RST_N && ((DMEM_Req && DMEM_Ack) || Bus_Err_M || Misaligned_M)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_bad++;
                $display("FAIL unexpected_resp: req=%b ack=%b err=%b mis=%b, required nothing",
                         DMEM_Req, DMEM_Ack, Bus_Err_M, Misaligned_M);
            end else begin
                e = exp_q.pop_front();
                kind_act = Misaligned_M ? 1 : (Bus_Err_M ? 2 : 0);
                chk("resp_kind", kind_act, e.kind);
                chk("resp_stall", {31'd0, Stall_M}, 32'd0);
                if (e.kind == 0) begin
                    chk("addr", DMEM_Addr, e.addr);
                    chk("we", {31'd0, DMEM_We}, {31'd0, e.we});
                    chk("be", {28'd0, DMEM_BE}, {28'd0, e.be});
                    if (e.we) chk("wdata", DMEM_WData, e.wdata);
                    chk("load_data", Data_Out_Ext_M, e.dout);
                end else begin
                    chk("no_req", {31'd0, DMEM_Req}, 32'd0);
                    chk("err_data", Data_Out_Ext_M, 32'd0);
                end
            end
        end
    end

    task automatic drop_inputs();
        Valid_M    = 1'b0;
        MEM_R_En_M = 1'b0;
        MEM_W_En_M = 1'b0;
        Hold_M     = 1'b0;
        DMEM_Ack   = 1'b0;
    endtask

    // delay: cycles before ack; delay > TO never acks.
    task automatic xact(input bit rd, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rdata, input int delay,
                        input bit hold, input int hold_cyc);
        exp_t e;
        int   stalls, last, exp_stall;
        e = model(rd, f3, addr, sd, rdata, delay > int'(TO));
        exp_q.push_back(e);
        last      = (e.kind == 1) ? 0 : (e.kind == 2) ? int'(TO) : delay;
        exp_stall = (e.kind == 1) ? 0 : last;
        Valid_M = 1'b1; MEM_R_En_M = rd; MEM_W_En_M = !rd; Funct3_M = f3;
        ALU_Out_M = addr; Store_Data_M = sd; Hold_M = hold;
        stalls = 0;
        for (int k = 0; k <= last; k++) begin
            DMEM_Ack   = (e.kind == 0) && (k == delay);
            DMEM_RData = DMEM_Ack ? rdata : $urandom;
            @(negedge CLK);
            if (Stall_M) stalls++;
            @(posedge CLK); #1;
        end
        chk("stall_cycles", stalls, exp_stall);
        DMEM_Ack = 1'b0;
        if (hold && e.kind != 1) begin
            for (int k = 0; k <= hold_cyc; k++) begin
                if (k == hold_cyc) Hold_M = 1'b0;
                DMEM_RData = $urandom;
                @(negedge CLK);
                chk("done_req", {30'd0, DMEM_Req, Stall_M}, 32'd0);
                chk("done_data", Data_Out_Ext_M, e.dout);
                @(posedge CLK); #1;
            end
        end
        drop_inputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            Valid_M    = 1'($urandom);
            DMEM_Ack   = 1'($urandom);
            DMEM_RData = $urandom;
            @(negedge CLK);
            chk("idle_ctl", {28'd0, DMEM_Req, Stall_M, Bus_Err_M, Misaligned_M}, 32'd0);
            chk("idle_data", Data_Out_Ext_M, 32'd0);
            @(posedge CLK); #1;
        end
        drop_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] f3s[5];
        bit         rd;
        logic [2:0] f3;
        logic [31:0] a;
        int          r, dly;
        f3s = '{B, H, W, BU, HU};

        // Reset with a live load and ack presented: every output must read 0.
        RST_N = 1'b0; Valid_M = 1'b1; MEM_R_En_M = 1'b1; MEM_W_En_M = 1'b0; Funct3_M = W;
        ALU_Out_M = 32'h0000_1234; Store_Data_M = 32'hFFFF_FFFF; Hold_M = 1'b0;
        DMEM_Ack = 1'b1; DMEM_RData = 32'hFFFF_FFFF;
        @(negedge CLK);
        chk("rst_ctl", {27'd0, DMEM_Req, DMEM_We, Stall_M, Bus_Err_M, Misaligned_M}, 32'd0);
        chk("rst_addr_wd", DMEM_Addr | DMEM_WData, 32'd0);
        chk("rst_be_data", Data_Out_Ext_M | {28'd0, DMEM_BE}, 32'd0);
        @(posedge CLK); #1;
        drop_inputs();
        RST_N = 1'b1;
        idle(2);

        xact(0, B,  32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 0);
        xact(1, H,  32'h0000_2002, 32'h0, 32'h8001_1234, 3, 0, 0);
        xact(1, BU, 32'h0000_2001, 32'h0, 32'h0000_F000, 1, 0, 0);
        xact(1, W,  32'h0000_3002, 32'h0, 32'h0, 0, 0, 0);
        xact(1, W,  32'h0000_4000, 32'h0, 32'h0, 99, 0, 0);
        // Late ack after the timeout must do nothing.
        DMEM_Ack = 1'b1; DMEM_RData = 32'hCAFE_F00D;
        @(negedge CLK);
        chk("late_ack", {28'd0, DMEM_Req, Stall_M, Bus_Err_M, Misaligned_M}, 32'd0);
        chk("late_ack_data", Data_Out_Ext_M, 32'd0);
        @(posedge CLK); #1;
        drop_inputs();
        xact(1, W,  32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 2, 1, 4);
        xact(1, H,  32'h0000_6000, 32'h0, 32'h1234_8765, 0, 1, 2);

        // Reset mid-WAIT abandons the access with no error pulse.
        Valid_M = 1'b1; MEM_R_En_M = 1'b1; Funct3_M = W; ALU_Out_M = 32'h0000_7000;
        DMEM_Ack = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        RST_N = 1'b0;
        @(negedge CLK);
        chk("rst_wait_ctl", {27'd0, DMEM_Req, DMEM_We, Stall_M, Bus_Err_M, Misaligned_M}, 32'd0);
        chk("rst_wait_data", Data_Out_Ext_M | DMEM_Addr, 32'd0);
        @(posedge CLK); #1;
        drop_inputs();
        RST_N = 1'b1;
        xact(1, W,  32'h0000_8000, 32'h0, 32'h0BAD_F00D, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 60; i++) begin
            rd = 1'($urandom);
            f3 = rd ? f3s[$urandom_range(0, 4)] : f3s[$urandom_range(0, 2)];
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'd2) ? 2'b00 :
                                                  (f3[1:0] == 2'd1) ? {a[1], 1'b0} : a[1:0];
            r   = $urandom_range(0, 9);
            dly = (r == 0) ? int'(TO) + 5 : (r == 1) ? int'(TO) : $urandom_range(0, 3);
            xact(rd, f3, a, $urandom, $urandom, dly, ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 3));
            idle($urandom_range(1, 2));
        end

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
